// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-deep output register.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   rx         asynchronous serial line, idle high, LSB first
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   byte available
//   rx_ready   consumer accepts the byte when rx_valid & rx_ready at an edge
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped because rx_valid was held
//
// Parameter
//   CLKS_PER_BIT  clk cycles per serial bit (minimum 4)
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      shreg;
   logic            rx_s1, rxs;

   logic            cnt_last, bit_hit, stop_hit, deliver, bad_stop;

   // two-flop synchronizer; resets to the idle level so reset never looks
   // like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rxs   <= rx_s1;
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!rxs) state_nxt = ST_START;
         ST_START: if (cnt == MID) state_nxt = rxs ? ST_IDLE : ST_DATA;
         ST_DATA:  if (cnt_last && idx == 3'd7) state_nxt = ST_STOP;
         ST_STOP:  if (cnt_last) state_nxt = rxs ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rxs) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // output/strobe decode
   always_comb begin
      cnt_last = (cnt == LAST);
      bit_hit  = (state == ST_DATA) && cnt_last;
      stop_hit = (state == ST_STOP) && cnt_last;
      deliver  = stop_hit && rxs;
      bad_stop = stop_hit && !rxs;
   end

   // bit timing counter, bit index and shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= 3'd0;
         shreg <= 8'h00;
      end else begin
         case (state)
            ST_START:         cnt <= (cnt == MID) ? '0 : cnt + 1'b1;
            ST_DATA, ST_STOP: cnt <= cnt_last ? '0 : cnt + 1'b1;
            default:          cnt <= '0;
         endcase
         if (state == ST_START) idx <= 3'd0;
         else if (bit_hit)      idx <= idx + 3'd1;
         if (bit_hit) shreg <= {rxs, shreg[7:1]};
      end
   end

   // output register and pulses; a delivery in the same cycle as an
   // accept replaces the byte without dropping rx_valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= bad_stop;
         overrun   <= deliver && rx_valid && !rx_ready;
         if (deliver && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16 with a byte scoreboard.
module tb_uart_rx;
   localparam int C = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun;

   int total = 0, bad = 0;
   int cyc = 0, t_fall = 0;
   int vrise = 0, vfall = 0, nfe = 0, nov = 0, viol = 0;
   int lat = -1, ov_cyc = -1;
   int vr0, vf0;
   logic pv = 1'b0, pfe = 1'b0, pov = 1'b0;
   logic [7:0] sb[$];
   logic [7:0] exp_b;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // serial frame driver; starts and ends #1 after a rising edge
   task automatic send(input logic [7:0] b, input logic stopb);
      rx = 1'b0;
      t_fall = cyc;
      repeat (C) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (C) @(posedge clk);
         #1;
      end
      rx = stopb;
      repeat (C) @(posedge clk);
      #1;
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // monitor: event counts and scoreboard pop on each accept
   always @(negedge clk) begin
      if (rx_valid && !pv) begin
         vrise++;
         lat = cyc - t_fall;
      end
      if (!rx_valid && pv) vfall++;
      if (frame_err) begin
         nfe++;
         if (pfe) viol++;
      end
      if (overrun) begin
         nov++;
         ov_cyc = cyc;
         if (pov) viol++;
      end
      if (rx_valid && rx_ready) begin
         chk("accept_has_expected", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            chk("rx_data_on_accept", {24'd0, rx_data}, {24'd0, exp_b});
         end
      end
      pv  = rx_valid;
      pfe = frame_err;
      pov = overrun;
   end

   initial begin
      // reset state
      idle(3);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_data", {24'd0, rx_data}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      idle(5);

      // good frame 0x55 and latency
      sb.push_back(8'h55);
      send(8'h55, 1'b1);
      idle(4);
      chk("lat_in_range", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
      chk("t1_vrise", vrise, 1);
      chk("t1_ferr", nfe, 0);
      chk("t1_sb_empty", sb.size(), 0);

      // 3-cycle glitch rejected, then 0x0F
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(3 * C);
      chk("glitch_no_valid", vrise, 1);
      chk("glitch_no_ferr", nfe, 0);
      sb.push_back(8'h0F);
      send(8'h0F, 1'b1);
      idle(4);
      chk("t2_vrise", vrise, 2);
      chk("t2_sb_empty", sb.size(), 0);

      // bad stop bit then line held low
      send(8'hA3, 1'b0);
      rx = 1'b0;
      idle(40);
      chk("brk_ferr_once", nfe, 1);
      chk("brk_no_valid", vrise, 2);
      rx = 1'b1;
      idle(3 * C);
      chk("brk_ferr_after", nfe, 1);
      chk("brk_no_valid_after", vrise, 2);
      chk("brk_no_ovr", nov, 0);

      // overrun with rx_ready low
      rx_ready = 1'b0;
      sb.push_back(8'h12);
      send(8'h12, 1'b1);
      send(8'h34, 1'b1);
      idle(4);
      chk("ovr_once", nov, 1);
      chk("ovr_at_stop", {31'd0, (ov_cyc - t_fall >= 154 && ov_cyc - t_fall <= 156)}, 32'd1);
      chk("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
      chk("ovr_data_held", {24'd0, rx_data}, 32'h12);
      chk("ovr_no_ferr", nfe, 1);
      rx_ready = 1'b1;
      idle(2);
      chk("ovr_valid_cleared", {31'd0, rx_valid}, 32'd0);
      chk("ovr_sb_empty", sb.size(), 0);

      // accept coincident with the next delivery
      rx_ready = 1'b0;
      sb.push_back(8'h12);
      sb.push_back(8'h34);
      send(8'h12, 1'b1);
      vf0 = vfall;
      fork
         send(8'h34, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      idle(4);
      chk("swap_valid_held", {31'd0, rx_valid}, 32'd1);
      chk("swap_no_drop", vfall, vf0);
      chk("swap_data", {24'd0, rx_data}, 32'h34);
      chk("swap_no_ovr", nov, 1);
      rx_ready = 1'b1;
      idle(2);
      chk("swap_sb_empty", sb.size(), 0);

      // reset during data bit 4
      vr0 = vrise;
      rx = 1'b0;
      idle(C);
      rx = 1'b1; idle(C);
      rx = 1'b0; idle(C);
      rx = 1'b1; idle(C);
      rx = 1'b0; idle(C);
      rx = 1'b1; idle(C / 2);
      rst = 1'b1;
      #2;
      chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
      chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
      idle(2);
      rst = 1'b0;
      idle(20 * C);
      chk("post_rst_no_valid", vrise, vr0);
      chk("post_rst_no_ferr", nfe, 1);
      chk("post_rst_no_ovr", nov, 1);
      sb.push_back(8'hC3);
      send(8'hC3, 1'b1);
      idle(4);
      chk("post_rst_vrise", vrise, vr0 + 1);
      chk("post_rst_sb_empty", sb.size(), 0);

      chk("pulse_width", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (legal minimum 4).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_data  output  8  received byte, stable while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  byte available.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready at a rising edge.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because rx_valid was held.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK with one bit counter (0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT)) and a 3-bit bit index.
REQ-012 IDLE: on rxs=0, SHALL go to START with counter=0; otherwise stay.
REQ-013 START: at counter = CLKS_PER_BIT/2-1 (integer division), SHALL sample rxs; 0 -> DATA with counter=0 and index=0; 1 -> IDLE (glitch rejected, no error pulse).
REQ-014 DATA: at counter = CLKS_PER_BIT-1, SHALL shift rxs into the shift register LSB-first, clear the counter, and increment the index; after the 8th bit (index wraps 7->0), SHALL go to STOP.
REQ-015 STOP: at counter = CLKS_PER_BIT-1, SHALL sample rxs; 1 -> deliver byte (REQ-016) and go to IDLE; 0 -> pulse frame_err for 1 cycle, discard the byte, and go to BREAK.
REQ-016 Delivery: if rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle, SHALL load rx_data and set rx_valid=1 on the next edge; if rx_valid=1 and rx_ready=0, SHALL leave rx_data unchanged and pulse overrun for 1 cycle.
REQ-017 BREAK: SHALL stay until rxs=1, then go to IDLE; no start is detected while in BREAK.
REQ-018 With rx_valid=1 and rx_ready=1 and no delivery in that cycle, SHALL clear rx_valid on the next edge.
REQ-019 rx_ready while rx_valid=0 SHALL have no effect.
REQ-020 Latency: from the first cycle rx is low to rx_valid high, SHALL be 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles ±1.
REQ-021 frame_err and overrun SHALL never be high for more than one consecutive cycle per event; both may not occur for the same frame.

Reset
REQ-022 On rst=1, SHALL asynchronously force rx_valid=0, rx_data=0, frame_err=0, overrun=0, state=IDLE, counter=0, index=0, and synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no valid, error, or overrun pulse; reception resumes with the next falling edge after release.

Verification (bench uses CLKS_PER_BIT=16, rx_ready=1 unless stated)
REQ-024 SHALL cover: frame 0x55 with good stop -> rx_valid=1 with rx_data=0x55 at 3+8+144 cycles (±1) after rx falls, frame_err=0.
REQ-025 SHALL cover: rx low for 3 cycles then high -> no rx_valid, no frame_err, FSM back in IDLE; a following frame 0x0F is received correctly.
REQ-026 SHALL cover: frame 0xA3 with stop bit 0 and rx held low 40 more cycles -> one frame_err pulse, rx_valid stays 0, no start detected until rx returns high.
REQ-027 SHALL cover: back-to-back frames 0x12, 0x34 with rx_ready=0 -> rx_data=0x12 held, one overrun pulse at the second stop sample; raising rx_ready then clears rx_valid.
REQ-028 SHALL cover: frames 0x12, 0x34 with rx_ready pulsed exactly in the cycle the 0x34 stop bit is sampled -> rx_valid stays 1 continuously, rx_data becomes 0x34, overrun=0.
REQ-029 SHALL cover: rst pulsed during data bit 4 of a frame -> all outputs 0 immediately, no pulses; the next frame 0xC3 is received correctly.
